// File: rtl/fb_scanout.sv
// Framebuffer scanout: display timing, dual-port video RAM and a control/status register file.
// Optional build macro FB_SCANOUT_IRQ_EN drives irq from the vblank flag; otherwise irq is tied low.
module fb_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned SCALE_LOG2 = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic                  irq,
  input  logic                  mem_en,
  input  logic [3:0]            mem_we,
  input  logic [ADDR_WIDTH:0]   mem_addr,
  input  logic [31:0]           mem_write,
  output logic [31:0]           mem_read
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] STRIDE_RST = ADDR_WIDTH'(H_ACTIVE >> SCALE_LOG2);

  logic [HW-1:0]         h;
  logic [VW-1:0]         v;
  logic                  hs_d1, vs_d1, de_d1;
  logic [23:0]           pix_rgb;
  logic [31:0]           vram [DEPTH];

  logic [ADDR_WIDTH-1:0] base_sh, base_act;
  logic [ADDR_WIDTH-1:0] stride_sh, stride_act;
  logic                  enable;
  logic [15:0]           frame_cnt;
  logic                  vblank_flag;

  logic                  h_last_c, v_last_c, vis_c, hs_low_c, vs_low_c, vblank_start_c;
  logic [ADDR_WIDTH-1:0] hs_c, vs_c, pix_addr_c;
  logic [ADDR_WIDTH-1:0] bus_word_c;
  logic                  ram_wr_c, reg_wr_c;
  logic [1:0]            reg_off_c;
  logic [31:0]           reg_rdata_c;

  // Timing decode and scanout address (pipeline stage 0)
  always_comb begin
    h_last_c       = (32'(h) == H_TOTAL - 1);
    v_last_c       = (32'(v) == V_TOTAL - 1);
    vis_c          = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hs_low_c       = (32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC);
    vs_low_c       = (32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC);
    vblank_start_c = (h == '0) && (32'(v) == V_ACTIVE);
    hs_c           = ADDR_WIDTH'(h >> SCALE_LOG2);
    vs_c           = ADDR_WIDTH'(v >> SCALE_LOG2);
    pix_addr_c     = base_act + vs_c * stride_act + hs_c;
  end

  // Bus decode
  always_comb begin
    bus_word_c = mem_addr[ADDR_WIDTH-1:0];
    reg_off_c  = mem_addr[1:0];
    ram_wr_c   = mem_en && !mem_addr[ADDR_WIDTH];
    reg_wr_c   = mem_en && mem_addr[ADDR_WIDTH] && (mem_we == 4'hF);
  end

  // Register read mux; unused bits read as zero
  always_comb begin
    reg_rdata_c = '0;
    case (reg_off_c)
      2'd0:    reg_rdata_c[ADDR_WIDTH-1:0] = base_sh;
      2'd1:    reg_rdata_c[ADDR_WIDTH-1:0] = stride_sh;
      2'd2:    reg_rdata_c[0] = enable;
      default: reg_rdata_c = {15'd0, vblank_flag, frame_cnt};
    endcase
  end

  // Video RAM: byte-masked bus write, scanout read (stage 1); reads see the pre-write word
  always_ff @(posedge clk) begin
    if (ram_wr_c) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) vram[bus_word_c][8*b +: 8] <= mem_write[8*b +: 8];
      end
    end
    pix_rgb <= vram[pix_addr_c][23:0];
  end

  // Bus read data, source chosen by the address MSB seen with mem_en
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read <= '0;
    end else if (mem_en) begin
      mem_read <= mem_addr[ADDR_WIDTH] ? reg_rdata_c : vram[bus_word_c];
    end
  end

  // Counters, sync/de delay line and output register (stage 2)
  always_ff @(posedge clk) begin
    if (rst) begin
      h     <= '0;
      v     <= '0;
      hs_d1 <= 1'b1;
      vs_d1 <= 1'b1;
      de_d1 <= 1'b0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      if (h_last_c) begin
        h <= '0;
        v <= v_last_c ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
      hs_d1 <= ~hs_low_c;
      vs_d1 <= ~vs_low_c;
      de_d1 <= vis_c;
      hsync <= hs_d1;
      vsync <= vs_d1;
      de    <= de_d1;
      if (de_d1 && enable) begin
        red   <= pix_rgb[23:16];
        green <= pix_rgb[15:8];
        blue  <= pix_rgb[7:0];
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

  // Control/status registers; shadows move to active copies at vblank start
  always_ff @(posedge clk) begin
    if (rst) begin
      base_sh     <= '0;
      base_act    <= '0;
      stride_sh   <= STRIDE_RST;
      stride_act  <= STRIDE_RST;
      enable      <= 1'b0;
      frame_cnt   <= '0;
      vblank_flag <= 1'b0;
    end else begin
      if (reg_wr_c && reg_off_c == 2'd0) base_sh   <= mem_write[ADDR_WIDTH-1:0];
      if (reg_wr_c && reg_off_c == 2'd1) stride_sh <= mem_write[ADDR_WIDTH-1:0];
      if (reg_wr_c && reg_off_c == 2'd2) enable    <= mem_write[0];
      if (vblank_start_c) begin
        // A shadow write landing on the transfer cycle is the value transferred
        base_act    <= (reg_wr_c && reg_off_c == 2'd0) ? mem_write[ADDR_WIDTH-1:0] : base_sh;
        stride_act  <= (reg_wr_c && reg_off_c == 2'd1) ? mem_write[ADDR_WIDTH-1:0] : stride_sh;
        frame_cnt   <= frame_cnt + 16'd1;
        vblank_flag <= 1'b1;
      end else if (reg_wr_c && reg_off_c == 2'd3 && mem_write[16]) begin
        vblank_flag <= 1'b0;
      end
    end
  end

`ifdef FB_SCANOUT_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= vblank_flag;
  end
`else
  assign irq = 1'b0;
`endif

endmodule
